elastic_buffer: RTL and testbench

ELASTIC_BUFFER -- requirements
Module: elastic_buffer

---
 rtl/elastic_buffer.sv | 87 ++++++++
 tb/tb_elastic_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer.sv
// Elastic buffer for 10b symbol streams: a circular FIFO that drops incoming
// SKP symbols when running full and re-sends the head SKP when running empty.
module elastic_buffer #(
  parameter int DATA_WIDTH   = 10,
  parameter int BUFFER_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buffer_mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  skp_removed,
  output logic                  skp_added
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] HI_HALF = CW'(BUFFER_DEPTH / 2 + 2);
  localparam logic [CW-1:0] LO_HALF = CW'(BUFFER_DEPTH / 2 - 2);
  localparam logic [CW-1:0] HI_EMPTY = CW'(4);
  localparam logic [CW-1:0] LO_EMPTY = CW'(1);
  localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'h0F4);
  localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'h30B);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_hi;
  logic [CW-1:0]         w_lo;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_skp;
  logic                  w_head_skp;
  logic                  w_drop_skp;
  logic                  w_hold_skp;
  logic                  w_store;
  logic                  w_pop;

  assign w_hi       = buffer_mode ? HI_EMPTY : HI_HALF;
  assign w_lo       = buffer_mode ? LO_EMPTY : LO_HALF;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_in_skp   = (data_in == SKP_NEG) || (data_in == SKP_POS);
  assign w_head_skp = (w_head == SKP_NEG) || (w_head == SKP_POS);

  // All decisions use the pre-edge count, so a same-cycle pop never frees room
  // for a write and a same-cycle write never satisfies a read.
  assign w_drop_skp = write_enable && !w_full && w_in_skp && (r_count >= w_hi);
  assign w_store    = write_enable && !w_full && !w_drop_skp;
  assign w_hold_skp = read_enable && !w_empty && (r_count <= w_lo) && w_head_skp;
  assign w_pop      = read_enable && !w_empty && !w_hold_skp;

  // Storage is left uncleared by reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_store && !rst) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      data_out    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      skp_removed <= 1'b0;
      skp_added   <= 1'b0;
    end else begin
      overflow    <= write_enable && w_full;
      underflow   <= read_enable && w_empty;
      skp_removed <= w_drop_skp;
      skp_added   <= w_hold_skp;
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (read_enable && !w_empty) data_out <= w_head;
      r_count <= r_count + CW'(w_store) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_elastic_buffer.sv
// Randomised plus directed bench for elastic_buffer; a queue-based reference
// model predicts each cycle's outputs, and a separate monitor checks them.
module tb_elastic_buffer;
  localparam int DW = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          buffer_mode = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [DW-1:0] data_out;
  logic          overflow, underflow, skp_removed, skp_added;

  elastic_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .buffer_mode(buffer_mode), .data_in(data_in),
    .write_enable(write_enable), .read_enable(read_enable), .data_out(data_out),
    .overflow(overflow), .underflow(underflow), .skp_removed(skp_removed),
    .skp_added(skp_added)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    f;  // {overflow, underflow, skp_removed, skp_added}
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  int            total = 0;
  int            bad = 0;

  function automatic logic is_skp(input logic [DW-1:0] w);
    return (w == 10'h0F4) || (w == 10'h30B);
  endfunction

  // Reference model: FIFO as a queue, thresholds straight from the mode rules.
  task automatic model(input logic r, input logic m, input logic we,
                       input logic re, input logic [DW-1:0] d);
    exp_t e;
    int c, hi, lo;
    logic ov, un, sr, sa;
    ov = 0; un = 0; sr = 0; sa = 0;
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      c  = mq.size();
      hi = m ? 4 : DEPTH / 2 + 2;
      lo = m ? 1 : DEPTH / 2 - 2;
      if (re) begin
        if (c == 0) un = 1;
        else begin
          m_dout = mq[0];
          if (c <= lo && is_skp(mq[0])) sa = 1;
          else void'(mq.pop_front());
        end
      end
      if (we) begin
        if (c == DEPTH) ov = 1;
        else if (is_skp(d) && c >= hi) sr = 1;
        else mq.push_back(d);
      end
    end
    e.d = m_dout;
    e.f = {ov, un, sr, sa};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic m, input logic we,
                      input logic re, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; buffer_mode = m; write_enable = we; read_enable = re; data_in = d;
    @(posedge clk);
    model(r, m, we, re, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (data_out !== e.d) begin
        bad++;
        $display("FAIL data_out t=%0t got=%h exp=%h", $time, data_out, e.d);
      end
      total++;
      if ({overflow, underflow, skp_removed, skp_added} !== e.f) begin
        bad++;
        $display("FAIL flags{ov,un,sr,sa} t=%0t got=%b exp=%b", $time,
                 {overflow, underflow, skp_removed, skp_added}, e.f);
      end
    end
  end

  function automatic logic [DW-1:0] rnd_word(input int skp_pct);
    logic [DW-1:0] w;
    if ($urandom_range(99) < skp_pct) return ($urandom_range(1) != 0) ? 10'h30B : 10'h0F4;
    w = DW'($urandom);
    if (is_skp(w)) w = 10'h155;
    return w;
  endfunction

  logic [DW-1:0] fill_w [DEPTH+1];

  initial begin
    fill_w[0] = 10'h0AA; fill_w[1] = 10'h2BB; fill_w[2] = 10'h1CC;
    fill_w[3] = 10'h3AA; fill_w[4] = 10'h111; fill_w[5] = 10'h092;
    for (int i = 6; i <= DEPTH; i++) fill_w[i] = DW'(i * 37 + 5);

    // Reset held with a write pending, then a read on the empty buffer.
    step(1, 0, 1, 0, 10'h123);
    step(1, 0, 1, 0, 10'h123);
    step(0, 0, 0, 1, 10'h000);

    // Fill to full, one overflow, then drain in order.
    for (int i = 0; i <= DEPTH; i++) step(0, 0, 1, 0, fill_w[i]);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 10'h000);
    step(0, 0, 0, 1, 10'h000);  // empty read keeps last data_out

    // SKP removal at count 10 (mode 0).
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, fill_w[i]);
    step(0, 0, 1, 0, 10'h0F4);
    step(0, 0, 1, 0, 10'h30B);

    // SKP insertion: mode 0 count 3, then mode 1 count 1.
    step(1, 0, 0, 0, 10'h000);
    step(0, 0, 1, 0, 10'h30B);
    step(0, 0, 1, 0, 10'h0AA);
    step(0, 0, 1, 0, 10'h2BB);
    step(0, 0, 0, 1, 10'h000);
    step(0, 0, 0, 1, 10'h000);
    step(1, 1, 0, 0, 10'h000);
    step(0, 1, 1, 0, 10'h0F4);
    step(0, 1, 0, 1, 10'h000);
    step(0, 1, 0, 1, 10'h000);

    // Steady count 8 with simultaneous read/write, pointers wrapping.
    step(1, 0, 0, 0, 10'h000);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, fill_w[i]);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, DW'(i * 29 + 3));
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 10'h000);

    // Random phases: write-heavy, read-heavy, balanced; modes and SKP density vary.
    for (int ph = 0; ph < 24; ph++) begin
      int wp, rp, sp;
      logic m;
      m  = $urandom_range(1);
      sp = $urandom_range(3) * 15;
      case (ph % 3)
        0: begin wp = 85; rp = 30; end
        1: begin wp = 30; rp = 85; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int i = 0; i < 60; i++)
        step(($urandom_range(299) == 0), m, ($urandom_range(99) < wp),
             ($urandom_range(99) < rp), rnd_word(sp));
    end

    step(0, 0, 0, 0, 10'h000);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
